input_event_fifo: RTL and testbench
===================================

Name: input_event_fifo

Overview:
- Converts per-player joystick button vectors from hps_io into a timestamped change-event queue.
- Generalised to N players and arbitrary button width.
- Sits between the hps_io joystick outputs and the system CPU interface, so software reads discrete press/release events instead of polling.
- Serialises simultaneous changes, coalesces changes while the queue is full, and flags overflow.

Parameters:
PLAYERS, 6, number of joystick channels scanned
BUTTON_W, 32, bits per joystick vector
DEPTH, 16, event FIFO entries (power of two, >=2)
TS_W, 33, timestamp width
IDX_W, $clog2(PLAYERS) (min 1), player index width (derived)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
joystick  in  PLAYERS*BUTTON_W  player p at [p*BUTTON_W +: BUTTON_W]
player_en  in  PLAYERS  per-player scan enable
timestamp  in  TS_W  free-running timestamp, sampled on push
flush  in  1  synchronous FIFO/overflow clear
ev_ready  in  1  consumer accepts head event
ev_valid  out  1  head event present
ev_player  out  IDX_W  player index of head event
ev_state  out  BUTTON_W  new button vector
ev_changed  out  BUTTON_W  bits that changed (old XOR new)
ev_time  out  TS_W  timestamp at push
count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: a change was held off because FIFO full

Behaviour:
- Reset (reset_n=0, async):
  - prev[] = 0, scan index = 0, FIFO pointers and count = 0, overflow = 0.
  - All outputs 0; ev_* are 0 when empty.
- Scanner:
  - Each cycle examines player idx; idx increments and wraps PLAYERS-1 -> 0.
  - Constant one player per cycle, no stall.
  - diff = joystick[idx] XOR prev[idx].
- Push conditions at the clock edge (all must hold): player_en[idx]=1, diff!=0, count<DEPTH (registered), flush=0.
  - Entry written: {idx, joystick[idx], diff, timestamp}.
  - prev[idx] <= joystick[idx].
- Full (count==DEPTH) with diff!=0 and enabled:
  - No push; prev[idx] unchanged; overflow <= 1.
  - The change is re-detected on a later scan, coalesced against the last reported state; no state is silently lost.
- Disabled player (player_en[idx]=0): prev[idx] <= joystick[idx] every visit; no events. Re-enabling produces no spurious event.
- Full is evaluated on registered count: a push is blocked even if a pop occurs in the same cycle.
- Pop: ev_valid & ev_ready at the edge advances the read pointer.
  - Simultaneous push and pop (count<DEPTH) leaves count unchanged.
- Output timing:
  - FIFO is show-ahead: ev_* reflect the head entry combinationally from registered storage.
  - ev_valid = (count!=0).
  - Push-to-ev_valid latency: 1 cycle (visible the cycle after the write edge when previously empty).
- Detection latency: a change is pushed within PLAYERS cycles of appearing on joystick.
- Ordering: FIFO order equals scan order; simultaneous changes on several players emerge in scan order from the current idx.
- flush=1:
  - Pointers, count and overflow cleared next edge; no push that cycle.
  - prev[] and idx retained.
  - ev_ready ignored.
- Pointers are log2(DEPTH) bits with natural wrap; count saturates logically at DEPTH and never exceeds it.
- overflow is cleared only by reset or flush.
- ev_time is the timestamp input value at the push edge, stored full width.

Test Plan:
1. Reset hold then release, all joystick=0, player_en all 1 -> for 20 cycles: ev_valid=0, count=0, overflow=0, no pushes.
2. Set player 0 bits 0x0000_0010, ev_ready=0 -> within 6 cycles count=1, ev_player=0, ev_state=0x10, ev_changed=0x10. Then clear to 0 -> second event with ev_state=0, ev_changed=0x10.
3. Scan index at 0; same cycle set player1=0x1, player3=0x2, player5=0x4 -> three events in order 1,3,5. ev_time strictly increasing, spaced by 2 cycles with a 1-per-cycle timestamp.
4. DEPTH=16, ev_ready=0; toggle player 2 bit 0 seventeen times with gaps >= PLAYERS cycles -> count stops at 16, overflow=1. Next, set player 2 to 0xFF -> after draining one entry, the next push carries ev_state=0xFF and ev_changed = last reported state XOR 0xFF.
5. player_en[4]=0; toggle player 4 to 0x80 -> no event. Set player_en[4]=1 -> still no event. Change to 0x81 -> one event, ev_changed=0x01.
6. With 5 entries queued, pulse reset_n low mid-cycle -> ev_valid, count and overflow drop to 0 immediately without a clock. With 5 entries queued and overflow=1, pulse flush -> next cycle count=0, overflow=0, and prev retained (no re-report of held buttons).

Source files
------------

// File: rtl/input_event_fifo_if.sv
// Event-queue handshake bundle for input_event_fifo.
// master drives the head event, slave returns ev_ready.
interface input_event_fifo_if #(
  parameter int PLAYERS  = 6,
  parameter int BUTTON_W = 32,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 33
);
  localparam int IDX_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                ev_ready;
  logic                ev_valid;
  logic [IDX_W-1:0]    ev_player;
  logic [BUTTON_W-1:0] ev_state;
  logic [BUTTON_W-1:0] ev_changed;
  logic [TS_W-1:0]     ev_time;
  logic [CNT_W-1:0]    count;
  logic                overflow;

  modport master (
    input  ev_ready,
    output ev_valid,
    output ev_player,
    output ev_state,
    output ev_changed,
    output ev_time,
    output count,
    output overflow
  );

  modport slave (
    output ev_ready,
    input  ev_valid,
    input  ev_player,
    input  ev_state,
    input  ev_changed,
    input  ev_time,
    input  count,
    input  overflow
  );
endinterface

// File: rtl/input_event_fifo.sv
// Round-robin joystick scanner feeding a show-ahead
// timestamped change-event FIFO with sticky overflow.
module input_event_fifo #(
  parameter int PLAYERS  = 6,
  parameter int BUTTON_W = 32,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 33
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [PLAYERS*BUTTON_W-1:0] joystick,
  input  logic [PLAYERS-1:0]          player_en,
  input  logic [TS_W-1:0]             timestamp,
  input  logic                        flush,
  input_event_fifo_if.master          ev
);
  localparam int IDX_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [BUTTON_W-1:0] r_prev [PLAYERS];
  logic [IDX_W-1:0]    r_idx;

  logic [IDX_W-1:0]    r_mem_p  [DEPTH];
  logic [BUTTON_W-1:0] r_mem_st [DEPTH];
  logic [BUTTON_W-1:0] r_mem_ch [DEPTH];
  logic [TS_W-1:0]     r_mem_ts [DEPTH];

  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;

  logic [BUTTON_W-1:0] w_joy;
  logic [BUTTON_W-1:0] w_diff;
  logic                w_en;
  logic                w_chg;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;

  assign w_joy   = joystick[r_idx*BUTTON_W +: BUTTON_W];
  assign w_diff  = w_joy ^ r_prev[r_idx];
  assign w_en    = player_en[r_idx];
  assign w_chg   = w_en & (|w_diff);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);
  // Full uses the registered count, so a same-cycle pop never frees a slot
  assign w_push  = w_chg & ~w_full & ~flush;
  assign w_pop   = w_valid & ev.ev_ready & ~flush;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
      for (int i = 0; i < PLAYERS; i++) begin
        r_prev[i] <= '0;
      end
    end else begin
      if (r_idx == IDX_W'(PLAYERS - 1)) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
      // A blocked change keeps prev stale so it is re-detected later
      if (!w_en || w_push) begin
        r_prev[r_idx] <= w_joy;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem_p[r_wptr]  <= r_idx;
      r_mem_st[r_wptr] <= w_joy;
      r_mem_ch[r_wptr] <= w_diff;
      r_mem_ts[r_wptr] <= timestamp;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_chg && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign ev.ev_valid   = w_valid;
  assign ev.ev_player  = w_valid ? r_mem_p[r_rptr]  : '0;
  assign ev.ev_state   = w_valid ? r_mem_st[r_rptr] : '0;
  assign ev.ev_changed = w_valid ? r_mem_ch[r_rptr] : '0;
  assign ev.ev_time    = w_valid ? r_mem_ts[r_rptr] : '0;
  assign ev.count      = r_count;
  assign ev.overflow   = r_overflow;
endmodule

// File: tb/tb_input_event_fifo.sv
// Bench for input_event_fifo: directed tables, corner
// sequences and a queue-based reference model.
module tb_input_event_fifo;
  localparam int P  = 6;
  localparam int BW = 32;
  localparam int D  = 16;
  localparam int TW = 33;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic [P*BW-1:0] joystick;
  logic [BW-1:0]   joy [P];
  logic [P-1:0]    player_en;
  logic [TW-1:0]   ts = '0;
  logic            flush;

  input_event_fifo_if #(
    .PLAYERS(P), .BUTTON_W(BW), .DEPTH(D), .TS_W(TW)
  ) ev_if ();

  input_event_fifo #(
    .PLAYERS(P), .BUTTON_W(BW), .DEPTH(D), .TS_W(TW)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .joystick (joystick),
    .player_en(player_en),
    .timestamp(ts),
    .flush    (flush),
    .ev       (ev_if)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) ts <= ts + 1'b1;

  always_comb begin
    joystick = '0;
    for (int i = 0; i < P; i++) joystick[i*BW +: BW] = joy[i];
  end

  typedef struct {
    int            p;
    logic [BW-1:0] st;
    logic [BW-1:0] ch;
    logic [TW-1:0] t;
  } ev_t;

  typedef struct {
    int            p;
    logic [BW-1:0] val;
    logic [BW-1:0] exp_ch;
  } vec_t;

  ev_t           mq[$];
  logic [BW-1:0] m_prev [P];
  bit            m_ovf;
  int            m_idx;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_idx = 0;
    for (int i = 0; i < P; i++) m_prev[i] = '0;
  endtask

  // Evaluated just before the edge on the inputs the DUT will sample
  task automatic model_step();
    int            p;
    logic [BW-1:0] j;
    bit            full;
    p    = m_idx;
    j    = joy[p];
    full = (mq.size() == D);
    if (mq.size() != 0 && ev_if.ev_ready && !flush) void'(mq.pop_front());
    if (!player_en[p]) begin
      m_prev[p] = j;
    end else if (j != m_prev[p] && !flush) begin
      if (!full) begin
        mq.push_back('{p: p, st: j, ch: j ^ m_prev[p], t: ts});
        m_prev[p] = j;
      end else begin
        m_ovf = 1;
      end
    end
    if (flush) begin
      mq.delete();
      m_ovf = 0;
    end
    m_idx = (m_idx + 1) % P;
  endtask

  task automatic cmp_model();
    bit            v;
    logic [63:0]   ep, es, ec, et;
    v  = (mq.size() != 0);
    ep = v ? 64'(mq[0].p)  : 64'd0;
    es = v ? 64'(mq[0].st) : 64'd0;
    ec = v ? 64'(mq[0].ch) : 64'd0;
    et = v ? 64'(mq[0].t)  : 64'd0;
    chk("m_valid",   64'(ev_if.ev_valid),   64'(v));
    chk("m_count",   64'(ev_if.count),      64'(mq.size()));
    chk("m_ovf",     64'(ev_if.overflow),   64'(m_ovf));
    chk("m_player",  64'(ev_if.ev_player),  ep);
    chk("m_state",   64'(ev_if.ev_state),   es);
    chk("m_changed", 64'(ev_if.ev_changed), ec);
    chk("m_time",    64'(ev_if.ev_time),    et);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_sys);
    #1;
    cmp_model();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pop1();
    ev_if.ev_ready = 1'b1;
    tick();
    ev_if.ev_ready = 1'b0;
  endtask

  vec_t          tbl [6];
  logic [BW-1:0] lastrep;
  logic [TW-1:0] tq [3];
  int            exp_p [3];
  int            k;

  initial begin
    for (int i = 0; i < P; i++) joy[i] = '0;
    player_en      = '1;
    flush          = 1'b0;
    ev_if.ev_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_valid", 64'(ev_if.ev_valid), 64'd0);
    chk("rst_count", 64'(ev_if.count),    64'd0);
    chk("rst_ovf",   64'(ev_if.overflow), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_count", 64'(ev_if.count), 64'd0);
    end

    tbl[0] = '{p: 0, val: 32'h0000_0010, exp_ch: 32'h0000_0010};
    tbl[1] = '{p: 0, val: 32'h0000_0000, exp_ch: 32'h0000_0010};
    tbl[2] = '{p: 2, val: 32'h0000_F0F0, exp_ch: 32'h0000_F0F0};
    tbl[3] = '{p: 2, val: 32'h0000_0F0F, exp_ch: 32'h0000_FFFF};
    tbl[4] = '{p: 5, val: 32'h8000_0001, exp_ch: 32'h8000_0001};
    tbl[5] = '{p: 5, val: 32'h0000_0001, exp_ch: 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      joy[tbl[i].p] = tbl[i].val;
      ticks(P);
      chk("tv_count",   64'(ev_if.count),      64'd1);
      chk("tv_player",  64'(ev_if.ev_player),  64'(tbl[i].p));
      chk("tv_state",   64'(ev_if.ev_state),   64'(tbl[i].val));
      chk("tv_changed", 64'(ev_if.ev_changed), 64'(tbl[i].exp_ch));
      pop1();
      chk("tv_drain",   64'(ev_if.count),      64'd0);
    end

    for (int i = 0; i < P && m_idx != 0; i++) tick();
    joy[1] = 32'h1;
    joy[3] = 32'h2;
    joy[5] = 32'h4;
    ticks(P);
    chk("ord_count", 64'(ev_if.count), 64'd3);
    exp_p = '{1, 3, 5};
    for (int i = 0; i < 3; i++) begin
      chk("ord_player", 64'(ev_if.ev_player), 64'(exp_p[i]));
      tq[i] = ev_if.ev_time;
      pop1();
    end
    chk("ord_dt01", 64'(tq[1] - tq[0]), 64'd2);
    chk("ord_dt12", 64'(tq[2] - tq[1]), 64'd2);

    lastrep = joy[2];
    for (int i = 0; i < 17; i++) begin
      joy[2] = joy[2] ^ 32'h1;
      if (i < 16) lastrep = joy[2];
      ticks(P);
    end
    chk("full_count", 64'(ev_if.count),    64'd16);
    chk("full_ovf",   64'(ev_if.overflow), 64'd1);
    joy[2] = 32'hFF;
    pop1();
    ticks(P);
    chk("refill_count", 64'(ev_if.count), 64'd16);
    for (int i = 0; i < 15; i++) pop1();
    chk("coal_state",   64'(ev_if.ev_state),   64'hFF);
    chk("coal_changed", 64'(ev_if.ev_changed), 64'(lastrep ^ 32'hFF));
    pop1();
    chk("coal_drain",   64'(ev_if.count),      64'd0);

    player_en[4] = 1'b0;
    joy[4] = 32'h80;
    ticks(2 * P);
    chk("dis_count", 64'(ev_if.count), 64'd0);
    player_en[4] = 1'b1;
    ticks(2 * P);
    chk("reen_count", 64'(ev_if.count), 64'd0);
    joy[4] = 32'h81;
    ticks(P);
    chk("reen_ev",      64'(ev_if.count),      64'd1);
    chk("reen_changed", 64'(ev_if.ev_changed), 64'h01);
    pop1();

    for (int i = 0; i < 5; i++) joy[i] = 32'h11 * (i + 1);
    ticks(P);
    chk("q5_count", 64'(ev_if.count), 64'd5);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ev_if.ev_valid), 64'd0);
    chk("arst_count", 64'(ev_if.count),    64'd0);
    chk("arst_ovf",   64'(ev_if.overflow), 64'd0);
    for (int i = 0; i < P; i++) joy[i] = '0;
    model_reset();
    #1;
    reset_n = 1'b1;
    ticks(P);
    chk("post_rst", 64'(ev_if.count), 64'd0);

    for (int i = 0; i < 17; i++) begin
      joy[1] = joy[1] ^ 32'h1;
      ticks(P);
    end
    ev_if.ev_ready = 1'b1;
    ticks(12);
    ev_if.ev_ready = 1'b0;
    ticks(P);
    chk("pf_count", 64'(ev_if.count),    64'd5);
    chk("pf_ovf",   64'(ev_if.overflow), 64'd1);
    flush = 1'b1;
    ev_if.ev_ready = 1'b1;
    tick();
    flush = 1'b0;
    ev_if.ev_ready = 1'b0;
    chk("fl_count", 64'(ev_if.count),    64'd0);
    chk("fl_ovf",   64'(ev_if.overflow), 64'd0);
    ticks(2 * P);
    chk("fl_held", 64'(ev_if.count), 64'd0);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) begin
        k = $urandom_range(P - 1);
        joy[k] = joy[k] ^ (32'h1 << $urandom_range(3));
      end
      if ($urandom_range(31) == 0) begin
        k = $urandom_range(P - 1);
        player_en[k] = ~player_en[k];
      end
      ev_if.ev_ready = ($urandom_range(2) == 0);
      flush = ($urandom_range(63) == 0);
      tick();
    end
    flush = 1'b0;
    ev_if.ev_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
